reaction_judge: RTL
===================

Name: reaction_judge

Overview:
- Game-play judge that sits directly upstream of the countdown timer/display block.
- Lights one of eight target LEDs, debounces the eight player buttons, and judges each round as a hit or a miss.
- Emits a one-cycle miss pulse, which the timer consumes as a time penalty, and a one-cycle hit pulse.
- Keeps saturating hit/miss counters and freezes when the timer raises game_over.

Parameters:
- TICK_DIV, 5000: clock cycles per tick (tick period 0.1 ms at 50 MHz).
- DEBOUNCE_TICKS, 100: consecutive stable ticks required before a button's debounced state changes.
- WINDOW_TICKS, 10000: ticks allowed in ACTIVE before a timeout miss.
- GAP_TICKS, 3000: ticks spent in GAP before the next target lights.
- LFSR_SEED, 16'hACE1: nonzero reset value of the target LFSR.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- start, input, 1: level; leaves IDLE when high.
- game_over, input, 1: from the timer; level, sticky until reset.
- btn, input, 8: raw, asynchronous, active-high player buttons.
- led, output, 8: one-hot target LED, or all zero.
- hit, output, 1: one-cycle pulse on a correct press.
- miss, output, 1: one-cycle pulse on a wrong press, multi-press or timeout.
- hit_count, output, 16: saturating count of hits.
- miss_count, output, 8: saturating count of misses.
- busy, output, 1: high in GAP, ACTIVE and RELEASE.

Behaviour:
- Reset values: led=0, hit=0, miss=0, hit_count=0, miss_count=0, busy=0. State=IDLE; LFSR=LFSR_SEED; tick divider, debounce counters and window counter=0; debounced buttons=0.
- Tick: the divider counts 0..TICK_DIV-1 and is free-running from reset. The tick is a one-cycle pulse when the divider equals TICK_DIV-1, after which the divider wraps to 0.
- Synchroniser: each btn bit passes through 2 flip-flops.
- Debounce, per bit: if the synced value equals the debounced value, its counter is cleared. Otherwise the counter increments on each tick; when it reaches DEBOUNCE_TICKS, the debounced value flips and the counter clears.
- Press event: a registered rising edge of a debounced bit, giving an 8-bit vector `press` that is valid for one cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advanced every clock.
- IDLE: led=0. When start=1, go to GAP with the window counter cleared.
- GAP: led=0. The window counter counts ticks. At GAP_TICKS, pick the target index from LFSR[2:0]. If the index equals the previous target, use (index+1) mod 8 instead. Set led to that one-hot value, clear the window counter, and go to ACTIVE.
- ACTIVE: the window counter counts ticks.
  - press == led exactly: hit pulse on the next cycle, then RELEASE.
  - press != 0 and press != led (wrong button or more than one button): miss pulse on the next cycle, then RELEASE.
  - Window counter reaches WINDOW_TICKS: timeout miss on the next cycle, then RELEASE.
  - A press event and a timeout in the same cycle: the press is judged and the timeout is ignored.
- RELEASE: led=0. Wait until all debounced buttons are 0, then go to GAP with the window counter cleared. Press events in GAP and RELEASE are ignored: no pulse and no count.
- Counters: hit_count increments with each hit pulse and miss_count with each miss pulse. Each saturates at all-ones, with no wrap.
- game_over=1 in any state:
  - Go to DONE on the next edge; led=0, busy=0.
  - No further hit or miss pulses; a judgement pending in that cycle is dropped.
  - Counters hold. DONE exits only on reset.
- hit and miss are never high in the same cycle. Each is exactly one clock wide.
- Latency from a btn edge to the hit/miss pulse: 2 sync cycles + up to (DEBOUNCE_TICKS+1)*TICK_DIV cycles + 2 cycles.
- Reset mid-round: all state returns to reset values immediately (asynchronous) and no pulse is emitted.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=2, WINDOW_TICKS=10, GAP_TICKS=3):
1. Reset, then start=1. After 12 cycles led goes one-hot (target 1 from seed 16'hACE1). Press the matching button cleanly → one hit pulse, hit_count=1, led=0. After release plus 12 cycles, a new target lights and differs from the previous one.
2. In ACTIVE, press a non-target button → one miss pulse, miss_count=1, hit_count unchanged. Press two buttons in the same cycle → one miss pulse.
3. In ACTIVE, no press → miss exactly 41 cycles after led lit (10 ticks + 1). Holding a button across RELEASE blocks GAP until it is released.
4. Toggle the target btn every 3 cycles for 40 cycles (bounce) → no press event and no pulse. Then hold it stable → exactly one hit.
5. Force 255 misses, then one more → miss_count stays 8'hFF. Preset hit_count near saturation → it stops at 16'hFFFF.
6. Assert game_over in the same cycle as a valid press → no pulse, led=0, busy=0, counters frozen. Further presses have no effect. Assert reset mid-ACTIVE → all outputs 0 asynchronously.

Source files
------------

// File: rtl/reaction_judge.sv
// -----------------------------------------------------------------------------
// reaction_judge
//
// Game-play judge for a reaction game. Lights one of eight target LEDs,
// debounces the eight player buttons and judges each round as a hit or a
// miss. The one-cycle miss pulse is consumed by the downstream countdown
// timer as a time penalty. Hit and miss counters saturate. The judge freezes
// in DONE once the timer raises game_over, and leaves DONE only on reset.
//
// Round flow: IDLE -> GAP -> ACTIVE -> RELEASE -> GAP -> ...
//   GAP     : LEDs dark for GAP_TICKS ticks, then a new target lights.
//   ACTIVE  : waits for a press event or a WINDOW_TICKS timeout.
//   RELEASE : LEDs dark until every debounced button is released.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   start       level; leaves IDLE while high
//   game_over   level from the timer; sticky until reset
//   btn[7:0]    raw asynchronous active-high player buttons
//   led[7:0]    one-hot target LED, or all zero
//   hit         one-cycle pulse on a correct press
//   miss        one-cycle pulse on a wrong press, multi-press or timeout
//   hit_count   saturating hit counter (16 bit)
//   miss_count  saturating miss counter (8 bit)
//   busy        high in GAP, ACTIVE and RELEASE
//
// The FSM state register is state_q (S_* encodings below) for observation.
// -----------------------------------------------------------------------------
module reaction_judge #(
    parameter int          TICK_DIV       = 5000,
    parameter int          DEBOUNCE_TICKS = 100,
    parameter int          WINDOW_TICKS   = 10000,
    parameter int          GAP_TICKS      = 3000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        game_over,
    input  logic [7:0]  btn,
    output logic [7:0]  led,
    output logic        hit,
    output logic        miss,
    output logic [15:0] hit_count,
    output logic [7:0]  miss_count,
    output logic        busy
);

    // -------------------------------------------------------------------------
    // Widths and limits
    // -------------------------------------------------------------------------
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam int WIN_MAXV = (WINDOW_TICKS > GAP_TICKS) ? WINDOW_TICKS : GAP_TICKS;
    localparam int WIN_W    = $clog2(WIN_MAXV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [WIN_W-1:0] WIN_END  = WIN_W'(WINDOW_TICKS);
    localparam logic [WIN_W-1:0] GAP_LAST = WIN_W'(GAP_TICKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GAP     = 3'd1;
    localparam logic [2:0] S_ACTIVE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // -------------------------------------------------------------------------
    // Tick divider: free-running 0..TICK_DIV-1, tick on the last count
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the raw buttons
    // -------------------------------------------------------------------------
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit debounce. Any cycle where the synced value agrees with the
    // debounced value restarts the count, so only DEBOUNCE_TICKS consecutive
    // disagreeing ticks flip the debounced bit.
    // -------------------------------------------------------------------------
    logic [7:0]       deb_q;
    logic [DEB_W-1:0] deb_cnt_q [8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < 8; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (tick) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_q[i]     <= ~deb_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Press events: registered rising edges of the debounced buttons.
    // press_q is high for exactly one cycle per debounced press.
    // -------------------------------------------------------------------------
    logic [7:0] deb_d_q;
    logic [7:0] press_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_d_q <= '0;
            press_q <= '0;
        end else begin
            deb_d_q <= deb_q;
            press_q <= deb_q & ~deb_d_q;
        end
    end

    // -------------------------------------------------------------------------
    // Target LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left so the
    // feedback bit enters at bit 0. Advances every clock.
    // -------------------------------------------------------------------------
    logic [15:0] lfsr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Target index: LFSR[2:0], bumped by one when it would repeat the last
    // target so the player always sees the light move.
    logic [2:0] prev_tgt_q;
    logic       prev_vld_q;
    logic [2:0] pick_idx;

    always_comb begin
        pick_idx = lfsr_q[2:0];
        if (prev_vld_q && (pick_idx == prev_tgt_q)) begin
            pick_idx = pick_idx + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Round FSM (next-state logic)
    // -------------------------------------------------------------------------
    logic [2:0]       state_q, state_n;
    logic [WIN_W-1:0] win_q,   win_n;
    logic [7:0]       led_q,   led_n;
    logic             hit_q,   hit_n;
    logic             miss_q,  miss_n;
    logic [2:0]       prev_tgt_n;
    logic             prev_vld_n;

    always_comb begin
        state_n    = state_q;
        win_n      = win_q;
        led_n      = led_q;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        prev_tgt_n = prev_tgt_q;
        prev_vld_n = prev_vld_q;

        case (state_q)
            S_IDLE: begin
                led_n = '0;
                if (start) begin
                    state_n = S_GAP;
                    win_n   = '0;
                end
            end

            S_GAP: begin
                led_n = '0;
                if (tick) begin
                    if (win_q == GAP_LAST) begin
                        led_n      = 8'b1 << pick_idx;
                        prev_tgt_n = pick_idx;
                        prev_vld_n = 1'b1;
                        win_n      = '0;
                        state_n    = S_ACTIVE;
                    end else begin
                        win_n = win_q + 1'b1;
                    end
                end
            end

            S_ACTIVE: begin
                // A press takes priority over a coinciding timeout.
                if (press_q != 8'h00) begin
                    if (press_q == led_q) begin
                        hit_n = 1'b1;
                    end else begin
                        miss_n = 1'b1;
                    end
                    led_n   = '0;
                    state_n = S_RELEASE;
                end else if (win_q == WIN_END) begin
                    miss_n  = 1'b1;
                    led_n   = '0;
                    state_n = S_RELEASE;
                end else if (tick) begin
                    win_n = win_q + 1'b1;
                end
            end

            S_RELEASE: begin
                led_n = '0;
                if (deb_q == 8'h00) begin
                    win_n   = '0;
                    state_n = S_GAP;
                end
            end

            S_DONE: begin
                led_n = '0;
            end

            default: begin
                led_n   = '0;
                state_n = S_IDLE;
            end
        endcase

        // game_over wins over everything, including a judgement made this cycle.
        if (game_over) begin
            state_n = S_DONE;
            led_n   = '0;
            hit_n   = 1'b0;
            miss_n  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Round FSM (registers)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            led_q      <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            prev_tgt_q <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            win_q      <= win_n;
            led_q      <= led_n;
            hit_q      <= hit_n;
            miss_q     <= miss_n;
            prev_tgt_q <= prev_tgt_n;
            prev_vld_q <= prev_vld_n;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating counters, updated on the same edge that raises the pulse
    // -------------------------------------------------------------------------
    logic [15:0] hit_cnt_q;
    logic [7:0]  miss_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_n && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (miss_n && (miss_cnt_q != 8'hFF)) begin
                miss_cnt_q <= miss_cnt_q + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign led        = led_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign busy       = (state_q == S_GAP) || (state_q == S_ACTIVE) || (state_q == S_RELEASE);

endmodule
